// File: rtl/multi_lane_deskew_fifo_pkg.sv
// Shared defaults for the multi-lane deskew FIFO and its neighbours
// (alignment-marker lock and lane reorder control).
package multi_lane_deskew_fifo_pkg;

  localparam int DEF_N_LANES    = 20;
  localparam int DEF_NB_DATA    = 66;
  localparam int DEF_FIFO_DEPTH = 20;
  localparam int DEF_MAX_SKEW   = 16;

  // Bit offset of lane k inside a packed multi-lane bus of lanes width w.
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/multi_lane_deskew_fifo_lane_delay_line.sv
// One deskew lane: circular RAM with a non-power-of-2 modulo read index,
// fill tracking, bypass, and a sticky out-of-range delay flag.
module multi_lane_deskew_fifo_lane_delay_line
  import multi_lane_deskew_fifo_pkg::*;
#(
  parameter int NB_DATA    = DEF_NB_DATA,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MAX_SKEW   = DEF_MAX_SKEW,
  parameter int NB_ADDR    = $clog2(FIFO_DEPTH),
  parameter int NB_DELAY   = $clog2(MAX_SKEW + 1)
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_valid,
  input  logic                i_bypass,
  input  logic                i_set_delay,
  input  logic [NB_DELAY-1:0] i_delay,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic [NB_ADDR-1:0]  i_wr_ptr,
  output logic [NB_DATA-1:0]  o_data,
  output logic                o_ready,
  output logic                o_cfg_error
);

  logic [NB_DATA-1:0]  r_mem [FIFO_DEPTH];
  logic [NB_DELAY-1:0] r_delay;
  logic [NB_DELAY-1:0] r_fill;
  logic [NB_DATA-1:0]  r_data;
  logic                r_ready;
  logic                r_cfg_error;

  logic [NB_ADDR:0]    w_wr_ext;
  logic [NB_ADDR:0]    w_dly_ext;
  logic [NB_ADDR-1:0]  w_rd_idx;
  logic                w_delay_bad;
  logic [NB_DELAY-1:0] w_delay_clamped;
  logic                w_fill_ready;

  // One extra bit so wr_ptr + FIFO_DEPTH cannot overflow before the subtract.
  assign w_wr_ext  = {1'b0, i_wr_ptr};
  assign w_dly_ext = (NB_ADDR + 1)'(r_delay);
  assign w_rd_idx  = (w_wr_ext >= w_dly_ext)
                   ? NB_ADDR'(w_wr_ext - w_dly_ext)
                   : NB_ADDR'(w_wr_ext + (NB_ADDR + 1)'(FIFO_DEPTH) - w_dly_ext);

  assign w_delay_bad     = (int'(i_delay) > MAX_SKEW);
  assign w_delay_clamped = w_delay_bad ? NB_DELAY'(MAX_SKEW) : i_delay;
  assign w_fill_ready    = (r_fill >= r_delay);

  always_ff @(posedge i_clock) begin
    if (i_valid) begin
      r_mem[i_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_delay     <= '0;
      r_fill      <= '0;
      r_data      <= '0;
      r_ready     <= 1'b0;
      r_cfg_error <= 1'b0;
    end else if (i_valid) begin
      if (i_bypass) begin
        r_data  <= i_data;
        r_ready <= 1'b1;
      end else begin
        r_ready <= w_fill_ready;
        // Zero delay reads the word being written this cycle, not the RAM.
        if (!w_fill_ready) begin
          r_data <= '0;
        end else if (r_delay == '0) begin
          r_data <= i_data;
        end else begin
          r_data <= r_mem[w_rd_idx];
        end
      end
      if (i_set_delay) begin
        r_delay <= w_delay_clamped;
        r_fill  <= '0;
        if (w_delay_bad) begin
          r_cfg_error <= 1'b1;
        end
      end else if (r_fill != NB_DELAY'(MAX_SKEW)) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  assign o_data      = r_data;
  assign o_ready     = r_ready;
  assign o_cfg_error = r_cfg_error;

endmodule

// File: rtl/multi_lane_deskew_fifo.sv
// N-lane programmable deskew FIFO: shared write pointer, per-lane delay lines,
// output valid and the all-lanes-ready reduction.
module multi_lane_deskew_fifo
  import multi_lane_deskew_fifo_pkg::*;
#(
  parameter int N_LANES    = DEF_N_LANES,
  parameter int NB_DATA    = DEF_NB_DATA,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MAX_SKEW   = DEF_MAX_SKEW,
  parameter int NB_ADDR    = $clog2(FIFO_DEPTH),
  parameter int NB_DELAY   = $clog2(MAX_SKEW + 1)
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic                        i_valid,
  input  logic                        i_bypass,
  input  logic                        i_set_delay,
  input  logic [N_LANES*NB_DELAY-1:0] i_delay,
  input  logic [N_LANES*NB_DATA-1:0]  i_data,
  output logic [N_LANES*NB_DATA-1:0]  o_data,
  output logic                        o_valid,
  output logic [N_LANES-1:0]          o_lane_ready,
  output logic                        o_all_ready,
  output logic [N_LANES-1:0]          o_cfg_error
);

  generate
    if (MAX_SKEW >= FIFO_DEPTH) begin : g_cfg_check
      $error("multi_lane_deskew_fifo: MAX_SKEW must be below FIFO_DEPTH");
    end
  endgenerate

  logic [NB_ADDR-1:0] r_wr_ptr;
  logic               r_valid;
  logic [N_LANES-1:0] w_lane_ready;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_wr_ptr <= (r_wr_ptr == NB_ADDR'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      multi_lane_deskew_fifo_lane_delay_line #(
        .NB_DATA    (NB_DATA),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_SKEW   (MAX_SKEW),
        .NB_ADDR    (NB_ADDR),
        .NB_DELAY   (NB_DELAY)
      ) u_lane (
        .i_clock     (i_clock),
        .i_reset_n   (i_reset_n),
        .i_valid     (i_valid),
        .i_bypass    (i_bypass),
        .i_set_delay (i_set_delay),
        .i_delay     (i_delay[lane_lsb(gi, NB_DELAY) +: NB_DELAY]),
        .i_data      (i_data[lane_lsb(gi, NB_DATA) +: NB_DATA]),
        .i_wr_ptr    (r_wr_ptr),
        .o_data      (o_data[lane_lsb(gi, NB_DATA) +: NB_DATA]),
        .o_ready     (w_lane_ready[gi]),
        .o_cfg_error (o_cfg_error[gi])
      );
    end
  endgenerate

  assign o_valid      = r_valid;
  assign o_lane_ready = w_lane_ready;
  assign o_all_ready  = &w_lane_ready;

endmodule

// File: tb/tb_multi_lane_deskew_fifo.sv
// Scoreboard bench for multi_lane_deskew_fifo: 4 lanes, depth 20, max skew 16.
module tb_multi_lane_deskew_fifo;

  localparam int N_LANES    = 4;
  localparam int NB_DATA    = 16;
  localparam int FIFO_DEPTH = 20;
  localparam int MAX_SKEW   = 16;
  localparam int NB_DELAY   = $clog2(MAX_SKEW + 1);
  localparam int DW         = N_LANES * NB_DATA;
  localparam int KW         = N_LANES * NB_DELAY;

  typedef struct packed {
    logic [DW-1:0]      data;
    logic [N_LANES-1:0] rdy;
    logic               all;
    logic [N_LANES-1:0] err;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_valid = 1'b0;
  logic               i_bypass = 1'b0;
  logic               i_set_delay = 1'b0;
  logic [KW-1:0]      i_delay = '0;
  logic [DW-1:0]      i_data = '0;
  logic [DW-1:0]      o_data;
  logic               o_valid;
  logic [N_LANES-1:0] o_lane_ready;
  logic               o_all_ready;
  logic [N_LANES-1:0] o_cfg_error;

  always #5 clk = ~clk;

  multi_lane_deskew_fifo #(
    .N_LANES    (N_LANES),
    .NB_DATA    (NB_DATA),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_SKEW   (MAX_SKEW)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_valid      (i_valid),
    .i_bypass     (i_bypass),
    .i_set_delay  (i_set_delay),
    .i_delay      (i_delay),
    .i_data       (i_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_lane_ready (o_lane_ready),
    .o_all_ready  (o_all_ready),
    .o_cfg_error  (o_cfg_error)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  exp_t               exp_q[$];
  exp_t               m_out;
  int                 m_delay[N_LANES];
  int                 m_fill[N_LANES];
  logic [N_LANES-1:0] m_err;
  logic [NB_DATA-1:0] m_hist[N_LANES][64];
  int                 m_n;

  function automatic logic [KW-1:0] pack_dly(input int a, input int b, input int c, input int d);
    logic [KW-1:0] r;
    r = '0;
    r[0*NB_DELAY +: NB_DELAY] = NB_DELAY'(a);
    r[1*NB_DELAY +: NB_DELAY] = NB_DELAY'(b);
    r[2*NB_DELAY +: NB_DELAY] = NB_DELAY'(c);
    r[3*NB_DELAY +: NB_DELAY] = NB_DELAY'(d);
    return r;
  endfunction

  function automatic logic [DW-1:0] ramp(input int n);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < N_LANES; k++) begin
      r[k*NB_DATA +: NB_DATA] = NB_DATA'((k << 12) | (n & 12'hfff));
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < N_LANES; k++) begin
      r[k*NB_DATA +: NB_DATA] = NB_DATA'($urandom);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_LANES; k++) begin
      m_delay[k] = 0;
      m_fill[k]  = 0;
    end
    m_err = '0;
    m_n   = 0;
    m_out = '0;
    exp_q.delete();
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare the DUT output.
  task automatic step(input logic v, input logic s, input logic b,
                      input logic [KW-1:0] dly, input logic [DW-1:0] din);
    exp_t e;
    e = '0;
    @(negedge clk);
    i_valid     = v;
    i_set_delay = s;
    i_bypass    = b;
    i_delay     = dly;
    i_data      = din;
    if (v) begin
      for (int k = 0; k < N_LANES; k++) begin
        logic r;
        int   nd;
        m_hist[k][m_n % 64] = din[k*NB_DATA +: NB_DATA];
        r = b || (m_fill[k] >= m_delay[k]);
        e.rdy[k] = r;
        if (b) begin
          e.data[k*NB_DATA +: NB_DATA] = din[k*NB_DATA +: NB_DATA];
        end else if (r) begin
          e.data[k*NB_DATA +: NB_DATA] = m_hist[k][(m_n - m_delay[k]) % 64];
        end
        if (s) begin
          nd = int'(dly[k*NB_DELAY +: NB_DELAY]);
          if (nd > MAX_SKEW) begin
            m_err[k] = 1'b1;
            nd = MAX_SKEW;
          end
          m_delay[k] = nd;
          m_fill[k]  = 0;
        end else if (m_fill[k] < MAX_SKEW) begin
          m_fill[k]++;
        end
      end
      m_n++;
      e.all = &e.rdy;
      e.err = m_err;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_valid !== v) begin
      errors++;
      $display("FAIL o_valid: got %b want %b", o_valid, v);
    end
    if (o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: output with no expected entry");
      end else begin
        m_out = exp_q.pop_front();
      end
    end
    checks += 4;
    if (o_data !== m_out.data) begin
      errors++;
      $display("FAIL o_data: got %h want %h", o_data, m_out.data);
    end
    if (o_lane_ready !== m_out.rdy) begin
      errors++;
      $display("FAIL o_lane_ready: got %b want %b", o_lane_ready, m_out.rdy);
    end
    if (o_all_ready !== m_out.all) begin
      errors++;
      $display("FAIL o_all_ready: got %b want %b", o_all_ready, m_out.all);
    end
    if (o_cfg_error !== m_out.err) begin
      errors++;
      $display("FAIL o_cfg_error: got %b want %b", o_cfg_error, m_out.err);
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_data, o_valid, o_lane_ready, o_all_ready, o_cfg_error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b rdy=%b all=%b err=%b want all 0",
               o_data, o_valid, o_lane_ready, o_all_ready, o_cfg_error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 6; n++) step(1'b1, 1'b0, 1'b0, '0, ramp(n));
    #2;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    #1;
    checks += 4;
    if (o_data !== '0) begin
      errors++;
      $display("FAIL midreset_data: got %h want 0", o_data);
    end
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_valid: got %b want 0", o_valid);
    end
    if (o_lane_ready !== '0 || o_all_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready: got %b/%b want 0/0", o_lane_ready, o_all_ready);
    end
    if (o_cfg_error !== '0) begin
      errors++;
      $display("FAIL midreset_err: got %b want 0", o_cfg_error);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (dut.r_wr_ptr !== '0) begin
      errors++;
      $display("FAIL wr_ptr_after_reset: got %0d want 0", dut.r_wr_ptr);
    end
    step(1'b1, 1'b0, 1'b0, '0, ramp(42));
  endtask

  task automatic test_ramp_delays();
    int first_l3;
    int first_all;
    first_l3  = -1;
    first_all = -1;
    step(1'b1, 1'b1, 1'b0, pack_dly(0, 3, 7, 16), ramp(100));
    for (int n = 0; n < 24; n++) begin
      step(1'b1, 1'b0, 1'b0, '0, ramp(200 + n));
      if (first_l3 < 0 && o_lane_ready[3] === 1'b1) first_l3 = n;
      if (first_all < 0 && o_all_ready === 1'b1) first_all = n;
    end
    checks += 2;
    if (first_l3 != 16) begin
      errors++;
      $display("FAIL lane3_ready_cycle: got %0d want 16", first_l3);
    end
    if (first_all != first_l3) begin
      errors++;
      $display("FAIL all_ready_cycle: got %0d want %0d", first_all, first_l3);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] sent[50];
    step(1'b1, 1'b1, 1'b0, pack_dly(16, 16, 16, 16), rand_data());
    for (int n = 0; n < 50; n++) begin
      sent[n] = rand_data();
      step(1'b1, 1'b0, 1'b0, '0, sent[n]);
    end
    checks++;
    if (o_data !== sent[33]) begin
      errors++;
      $display("FAIL wrap_final: got %h want %h", o_data, sent[33]);
    end
  endtask

  task automatic test_cfg_error();
    step(1'b1, 1'b1, 1'b0, pack_dly(0, 25, 0, 0), ramp(300));
    checks++;
    if (o_cfg_error !== 4'b0010) begin
      errors++;
      $display("FAIL cfg_error_set: got %b want 0010", o_cfg_error);
    end
    for (int n = 0; n < 20; n++) step(1'b1, 1'b0, 1'b0, '0, ramp(310 + n));
    step(1'b1, 1'b1, 1'b0, pack_dly(0, 3, 0, 0), ramp(340));
    for (int n = 0; n < 5; n++) step(1'b1, 1'b0, 1'b0, '0, ramp(350 + n));
    checks++;
    if (o_cfg_error !== 4'b0010) begin
      errors++;
      $display("FAIL cfg_error_sticky: got %b want 0010", o_cfg_error);
    end
  endtask

  task automatic test_valid_toggle();
    int seen;
    int driven;
    seen   = 0;
    driven = 0;
    step(1'b1, 1'b1, 1'b0, pack_dly(2, 2, 2, 2), ramp(400));
    for (int n = 0; n < 16; n++) begin
      logic v;
      v = (n % 2 == 0);
      // A load strobe without valid must be ignored.
      step(v, (n == 5), 1'b0, pack_dly(9, 9, 9, 9), ramp(410 + n));
      driven += int'(v);
      seen   += int'(o_valid);
    end
    checks++;
    if (seen != driven) begin
      errors++;
      $display("FAIL toggle_valid_count: got %0d want %0d", seen, driven);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] prev;
    step(1'b1, 1'b0, 1'b1, '0, ramp(500));
    step(1'b1, 1'b0, 1'b1, '0, ramp(501));
    step(1'b1, 1'b1, 1'b1, pack_dly(1, 1, 1, 1), ramp(502));
    step(1'b1, 1'b0, 1'b1, '0, ramp(503));
    step(1'b1, 1'b0, 1'b1, '0, ramp(504));
    prev = ramp(504);
    for (int n = 0; n < 4; n++) begin
      step(1'b1, 1'b0, 1'b0, '0, ramp(510 + n));
      checks++;
      if (o_all_ready !== 1'b1 || o_data !== prev) begin
        errors++;
        $display("FAIL bypass_exit: got rdy=%b data=%h want rdy=1 data=%h", o_all_ready, o_data, prev);
      end
      prev = ramp(510 + n);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_delays();
    test_wrap();
    test_cfg_error();
    test_valid_toggle();
    test_bypass();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_lane_deskew_fifo.md
Name: multi_lane_deskew_fifo

Overview:
- N_LANES parallel programmable delay lines, one per PCS lane, each a circular buffer of FIFO_DEPTH words.
- Each lane delays its NB_DATA block stream by a per-lane count of valid cycles, so skewed lanes come out aligned.
- Sits between lane alignment-marker lock and lane reorder/deskew control. Control loads all lane delays in one shot once skew is measured.
- Adds over the single-lane FIFO: per-lane delays, non-power-of-2 wrap, fill tracking, bypass, delay-range error flag.

Parameters:
- N_LANES, 20, number of lanes.
- NB_DATA, 66, bits per lane word.
- FIFO_DEPTH, 20, words per lane; any integer ≥ MAX_SKEW+1, not required to be a power of 2.
- MAX_SKEW, 16, largest legal delay in valid cycles; elaboration error if MAX_SKEW ≥ FIFO_DEPTH.
- NB_ADDR, $clog2(FIFO_DEPTH), pointer width.
- NB_DELAY, $clog2(MAX_SKEW+1), per-lane delay field width.

Ports:
- i_clock  in  1  single clock.
- i_reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_valid  in  1  clock enable; all pointers and counters advance only when high.
- i_bypass  in  1  1 = every lane passes straight through with 1-cycle latency; delays ignored.
- i_set_delay  in  1  load i_delay (takes effect only when i_valid is high).
- i_delay  in  N_LANES*NB_DELAY  per-lane delays; lane k occupies bits [k*NB_DELAY +: NB_DELAY].
- i_data  in  N_LANES*NB_DATA  lane words, same packing.
- o_data  out  N_LANES*NB_DATA  delayed lane words, same packing.
- o_valid  out  1  i_valid delayed by 1 cycle.
- o_lane_ready  out  N_LANES  lane k's output holds real data, not fill.
- o_all_ready  out  1  AND of o_lane_ready.
- o_cfg_error  out  N_LANES  sticky; lane k was given a delay > MAX_SKEW.

Behaviour:
- Reset (async assert, sync deassert externally): wr_ptr=0, delay regs=0, fill counters=0. All outputs 0. Storage RAM is not reset. Asserting reset mid-stream clears state immediately.
- Write: on i_valid, every lane writes i_data to mem[wr_ptr]. wr_ptr is shared by all lanes. It wraps FIFO_DEPTH-1 → 0, else increments.
- Read index per lane: rd_k = wr_ptr - d_k if wr_ptr ≥ d_k, else wr_ptr + FIFO_DEPTH - d_k. Computed combinationally from the current wr_ptr.
- d_k = 0: forward the same-cycle input (write-first bypass), never a stale RAM word.
- Output register: on i_valid, o_data lane k ← word written d_k valid cycles earlier. Latency is 1 clock plus d_k valid cycles. When i_valid=0, o_data holds.
- Fill: per-lane counter saturates at MAX_SKEW and increments on each i_valid write. o_lane_ready[k] is registered and equals (count_k ≥ d_k), updated on i_valid. While not ready, lane k's o_data is forced to 0.
- Load: when i_set_delay && i_valid:
  - latch each d_k; a value > MAX_SKEW is clamped to MAX_SKEW and sets o_cfg_error[k];
  - clear all fill counters to 0;
  - the word in that cycle is written, but its output uses the old delays;
  - new delays apply from the next valid cycle.
- i_set_delay without i_valid is ignored.
- o_cfg_error is cleared only by reset.
- Bypass: o_data ← i_data on i_valid, and o_lane_ready is forced all-1. Writes and fill counting continue, so leaving bypass is glitch-free once counters have filled.
- Simultaneous set and bypass: delays are loaded; bypass output still wins.

Decomposition:
- Shared include: lane-packing macros and lane-count defaults (N_LANES, NB_DATA, MAX_SKEW), reused by the alignment and reorder blocks.
- One sub-module, lane_delay_line: single-lane RAM, modulo read index, fill counter, ready/error flags. Generated N_LANES times.
- The top level holds the shared wr_ptr, the output valid, and the ready reduction.

Test Plan:
- Reset mid-stream with N_LANES=4, DEPTH=20 → all outputs 0 in the same cycle; wr_ptr=0 after release.
- Delays {0,3,7,16}, counting ramp per lane, i_valid=1 → lane k output = input from d_k valid cycles earlier. Lane 3 ready after 16 writes; o_all_ready asserts on the same cycle as lane 3.
- 50 valid cycles, delay 16, DEPTH=20 (non-power-of-2) → no data corruption across wr_ptr wraps 19→0; rd index is correct at wr_ptr<16.
- Delay 25 on lane 1 → clamped to 16, o_cfg_error=4'b0010, stays set after a reload with a legal value.
- i_valid toggling 1010 with delay 2 → output advances only on valid cycles; o_valid mirrors i_valid one cycle later.
- Bypass on, then reload {1,1,1,1} and drop bypass after 2 cycles → immediate 1-cycle passthrough, then 1-word delayed data with ready=1, no zero gap.
